// File: rtl/arc4_sched_if.sv
// Interface for the ARC4 scheduler: start handshake, per-engine launch/status and memory ports,
// and the shared S-memory write port.
interface arc4_sched_if;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned SW = 2;

  logic          en;
  logic          rdy;
  logic          done;
  logic [SW-1:0] stage;

  logic          init_en;
  logic          init_rdy;
  logic [AW-1:0] init_addr;
  logic [DW-1:0] init_wrdata;
  logic          init_wren;

  logic          ksa_en;
  logic          ksa_rdy;
  logic [AW-1:0] ksa_addr;
  logic [DW-1:0] ksa_wrdata;
  logic          ksa_wren;

  logic          prga_en;
  logic          prga_rdy;
  logic [AW-1:0] prga_addr;
  logic [DW-1:0] prga_wrdata;
  logic          prga_wren;

  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wrdata;
  logic          s_wren;

  modport slave (
    input  en,
    input  init_rdy, init_addr, init_wrdata, init_wren,
    input  ksa_rdy,  ksa_addr,  ksa_wrdata,  ksa_wren,
    input  prga_rdy, prga_addr, prga_wrdata, prga_wren,
    output rdy, done, stage,
    output init_en, ksa_en, prga_en,
    output s_addr, s_wrdata, s_wren
  );

  modport master (
    output en,
    output init_rdy, init_addr, init_wrdata, init_wren,
    output ksa_rdy,  ksa_addr,  ksa_wrdata,  ksa_wren,
    output prga_rdy, prga_addr, prga_wrdata, prga_wren,
    input  rdy, done, stage,
    input  init_en, ksa_en, prga_en,
    input  s_addr, s_wrdata, s_wren
  );
endinterface

// File: rtl/arc4_sched.sv
// Sequences the init, KSA and PRGA engines, one launch pulse each, and routes the active
// engine's S-memory write port onto the shared memory.
module arc4_sched (
  input logic         clk,
  input logic         rst,
  arc4_sched_if.slave bus
);
  localparam int unsigned SW = 2;

  typedef enum logic [2:0] {
    IDLE,
    START_INIT,
    WAIT_INIT,
    START_KSA,
    WAIT_KSA,
    START_PRGA,
    WAIT_PRGA,
    FINISH
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          busy_seen;
  logic          busy_next;
  logic          in_start;
  logic [SW-1:0] stage;
  logic          wren_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy_seen <= 1'b0;
    end else begin
      state     <= state_next;
      busy_seen <= busy_next;
    end
  end

  // An engine is only considered finished after it has been seen busy and then ready again.
  always_comb begin
    state_next   = state;
    busy_next    = busy_seen;
    in_start     = 1'b0;
    stage        = '0;
    bus.rdy      = 1'b0;
    bus.done     = 1'b0;
    bus.init_en  = 1'b0;
    bus.ksa_en   = 1'b0;
    bus.prga_en  = 1'b0;
    case (state)
      IDLE: begin
        bus.rdy = 1'b1;
        if (bus.en) state_next = START_INIT;
      end
      START_INIT: begin
        stage     = SW'(1);
        in_start  = 1'b1;
        busy_next = 1'b0;
        if (bus.init_rdy) begin
          bus.init_en = 1'b1;
          state_next  = WAIT_INIT;
        end
      end
      WAIT_INIT: begin
        stage = SW'(1);
        if (!bus.init_rdy) begin
          busy_next = 1'b1;
        end else if (busy_seen) begin
          busy_next  = 1'b0;
          state_next = START_KSA;
        end
      end
      START_KSA: begin
        stage     = SW'(2);
        in_start  = 1'b1;
        busy_next = 1'b0;
        if (bus.ksa_rdy) begin
          bus.ksa_en = 1'b1;
          state_next = WAIT_KSA;
        end
      end
      WAIT_KSA: begin
        stage = SW'(2);
        if (!bus.ksa_rdy) begin
          busy_next = 1'b1;
        end else if (busy_seen) begin
          busy_next  = 1'b0;
          state_next = START_PRGA;
        end
      end
      START_PRGA: begin
        stage     = SW'(3);
        in_start  = 1'b1;
        busy_next = 1'b0;
        if (bus.prga_rdy) begin
          bus.prga_en = 1'b1;
          state_next  = WAIT_PRGA;
        end
      end
      WAIT_PRGA: begin
        stage = SW'(3);
        if (!bus.prga_rdy) begin
          busy_next = 1'b1;
        end else if (busy_seen) begin
          busy_next  = 1'b0;
          state_next = FINISH;
        end
      end
      FINISH: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Writes are gated off until the selected engine has actually been launched.
  always_comb begin
    bus.stage    = stage;
    bus.s_addr   = '0;
    bus.s_wrdata = '0;
    wren_sel     = 1'b0;
    case (stage)
      SW'(1): begin
        bus.s_addr   = bus.init_addr;
        bus.s_wrdata = bus.init_wrdata;
        wren_sel     = bus.init_wren;
      end
      SW'(2): begin
        bus.s_addr   = bus.ksa_addr;
        bus.s_wrdata = bus.ksa_wrdata;
        wren_sel     = bus.ksa_wren;
      end
      SW'(3): begin
        bus.s_addr   = bus.prga_addr;
        bus.s_wrdata = bus.prga_wrdata;
        wren_sel     = bus.prga_wren;
      end
      default: wren_sel = 1'b0;
    endcase
    bus.s_wren = wren_sel & ~in_start;
  end
endmodule

// File: tb/tb_arc4_sched.sv
// Randomised bench for arc4_sched: engine models, a timeline reference model of each run,
// and a scoreboard monitor that checks launch/done events and per-cycle outputs.
module tb_arc4_sched;
  typedef struct {
    int s0, s1, s2;
    int e0, e1, e2;
    int f;
  } run_t;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk;
  logic rst;

  arc4_sched_if bus ();

  arc4_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] drv_addr [3];
  logic [7:0] drv_data [3];
  logic       drv_wren [3];
  logic       eng_rdy  [3];
  logic       eng_en   [3];

  assign bus.init_rdy    = eng_rdy[0];
  assign bus.ksa_rdy     = eng_rdy[1];
  assign bus.prga_rdy    = eng_rdy[2];
  assign bus.init_addr   = drv_addr[0];
  assign bus.ksa_addr    = drv_addr[1];
  assign bus.prga_addr   = drv_addr[2];
  assign bus.init_wrdata = drv_data[0];
  assign bus.ksa_wrdata  = drv_data[1];
  assign bus.prga_wrdata = drv_data[2];
  assign bus.init_wren   = drv_wren[0];
  assign bus.ksa_wren    = drv_wren[1];
  assign bus.prga_wren   = drv_wren[2];
  assign eng_en[0]       = bus.init_en;
  assign eng_en[1]       = bus.ksa_en;
  assign eng_en[2]       = bus.prga_en;

  int   cyc;
  int   n_cmp;
  int   n_bad;
  int   next_free;
  run_t runs[$];
  ev_t  evq[$];
  run_t last_run;

  int   cb[3], cp[3], cd[3];
  bit   cfg_new[3];
  bit   eng_rst_req;
  int   k[3], hold[3];
  bit   act[3], launched[3];
  logic nxt_rdy[3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
    end
  end

  function automatic void chk(input bit ok, input string name, input string detail);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: %s", name, cyc, detail);
    end
  endfunction

  // Expected scheduler view of cycle c, derived from the run timelines.
  function automatic void exp_at(input int c, output int st, output bit rd, output bit dn,
                                 output bit strt);
    st = 0; rd = 1'b1; dn = 1'b0; strt = 1'b0;
    foreach (runs[i]) begin
      if (c >= runs[i].s0 && c <= runs[i].f) begin
        rd = 1'b0;
        if (c == runs[i].f) begin
          dn = 1'b1;
        end else if (c < runs[i].s1) begin
          st = 1; strt = (c <= runs[i].e0);
        end else if (c < runs[i].s2) begin
          st = 2; strt = (c <= runs[i].e1);
        end else begin
          st = 3; strt = (c <= runs[i].e2);
        end
      end
    end
  endfunction

  // Random engine-side memory traffic, including writes from non-selected engines.
  initial begin
    for (int i = 0; i < 3; i++) begin
      drv_addr[i] = '0; drv_data[i] = '0; drv_wren[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        drv_addr[i] = 8'($urandom);
        drv_data[i] = 8'($urandom);
        drv_wren[i] = 1'($urandom);
      end
    end
  end

  // Engine models: optional not-ready hold, p premature-ready cycles, then b busy cycles.
  initial begin
    eng_rst_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      eng_rdy[i] = 1'b1; nxt_rdy[i] = 1'b1; act[i] = 1'b0; launched[i] = 1'b1;
      k[i] = 0; hold[i] = 0; cfg_new[i] = 1'b0; cb[i] = 1; cp[i] = 0; cd[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) eng_rdy[i] = nxt_rdy[i];
      #1;
      if (eng_rst_req) begin
        eng_rst_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
          act[i] = 1'b0; launched[i] = 1'b1; hold[i] = 0; nxt_rdy[i] = 1'b1;
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (cfg_new[i]) begin
          cfg_new[i]  = 1'b0;
          hold[i]     = cd[i];
          launched[i] = 1'b0;
          nxt_rdy[i]  = (cd[i] == 0);
        end
        if (act[i]) begin
          k[i]++;
          nxt_rdy[i] = (k[i] <= cp[i]) || (k[i] > cp[i] + cb[i]);
          if (k[i] > cp[i] + cb[i]) act[i] = 1'b0;
        end else if (!launched[i] && eng_en[i] === 1'b1) begin
          act[i] = 1'b1; launched[i] = 1'b1; k[i] = 1;
          nxt_rdy[i] = (cp[i] >= 1);
        end else if (!launched[i] && hold[i] > 0 && bus.stage === 2'(i + 1)) begin
          hold[i]--;
          if (hold[i] == 0) nxt_rdy[i] = 1'b1;
        end
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    int         st;
    bit         rd, dn, strt;
    logic [7:0] ea, ed;
    logic       ew;
    logic       evs[4];
    ev_t        e;
    forever begin
      @(negedge clk);
      #2;
      while (runs.size() > 0 && runs[0].f < cyc - 2) void'(runs.pop_front());
      exp_at(cyc, st, rd, dn, strt);
      chk(bus.rdy === rd && bus.done === dn && bus.stage === 2'(st), "ctrl",
          $sformatf("rdy/done/stage got %b/%b/%0d expected %b/%b/%0d",
                    bus.rdy, bus.done, bus.stage, rd, dn, st));
      ea = '0; ed = '0; ew = 1'b0;
      if (st != 0) begin
        ea = drv_addr[st-1];
        ed = drv_data[st-1];
        ew = drv_wren[st-1] & ~strt;
      end
      chk(bus.s_addr === ea && bus.s_wrdata === ed && bus.s_wren === ew, "s_bus",
          $sformatf("addr/data/wren got %h/%h/%b expected %h/%h/%b",
                    bus.s_addr, bus.s_wrdata, bus.s_wren, ea, ed, ew));
      chk((32'(bus.init_en) + 32'(bus.ksa_en) + 32'(bus.prga_en)) <= 1, "en_onehot",
          $sformatf("init/ksa/prga en got %b%b%b expected at most one high",
                    bus.init_en, bus.ksa_en, bus.prga_en));
      evs[0] = bus.init_en; evs[1] = bus.ksa_en; evs[2] = bus.prga_en; evs[3] = bus.done;
      for (int i = 0; i < 4; i++) begin
        if (evs[i] === 1'b1) begin
          if (evq.size() == 0) begin
            chk(1'b0, "event", $sformatf("got kind %0d with none expected", i));
          end else begin
            e = evq.pop_front();
            chk(e.kind == i && e.cyc == cyc, "event",
                $sformatf("got kind %0d at cyc %0d expected kind %0d at cyc %0d",
                          i, cyc, e.kind, e.cyc));
          end
        end
      end
    end
  end

  // Issue a run at a negedge+3 point; the reference timeline is pushed to the scoreboard.
  task automatic issue(input int b0, input int b1, input int b2, input int p0, input int p1,
                       input int p2, input int d1, input int d2, input bit keep_en);
    run_t r;
    while (cyc < next_free) begin
      @(negedge clk); #3;
    end
    r.s0 = cyc + 1;
    r.e0 = r.s0;
    r.s1 = r.e0 + p0 + b0 + 2;
    r.e1 = r.s1 + d1;
    r.s2 = r.e1 + p1 + b1 + 2;
    r.e2 = r.s2 + d2;
    r.f  = r.e2 + p2 + b2 + 2;
    runs.push_back(r);
    evq.push_back('{0, r.e0});
    evq.push_back('{1, r.e1});
    evq.push_back('{2, r.e2});
    evq.push_back('{3, r.f});
    next_free = r.f + 1;
    last_run  = r;
    cb[0] = b0; cb[1] = b1; cb[2] = b2;
    cp[0] = p0; cp[1] = p1; cp[2] = p2;
    cd[0] = 0;  cd[1] = d1; cd[2] = d2;
    for (int i = 0; i < 3; i++) cfg_new[i] = 1'b1;
    bus.en = 1'b1;
    if (!keep_en) begin
      @(negedge clk); #3;
      bus.en = 1'b0;
    end
  endtask

  initial begin
    int budget;
    n_cmp = 0; n_bad = 0; next_free = 0;
    rst = 1'b1;
    bus.en = 1'b0;
    #1;
    chk(bus.rdy === 1'b1 && bus.done === 1'b0 && bus.stage === 2'd0 && bus.init_en === 1'b0 &&
        bus.ksa_en === 1'b0 && bus.prga_en === 1'b0 && bus.s_wren === 1'b0 &&
        bus.s_addr === 8'h00 && bus.s_wrdata === 8'h00, "reset_async",
        $sformatf("rdy/done/stage/wren got %b/%b/%0d/%b expected 1/0/0/0",
                  bus.rdy, bus.done, bus.stage, bus.s_wren));
    repeat (3) @(negedge clk);
    #3;
    rst = 1'b0;
    next_free = cyc;
    issue(256, 768, 64, 0, 0, 0, 0, 0, 1'b0);
    issue(20, 30, 15, 0, 0, 0, 10, 0, 1'b0);
    issue(10, 10, 8, 0, 0, 3, 0, 0, 1'b0);
    for (int r = 0; r < 6; r++) begin
      issue(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)), int'($urandom_range(1, 12)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'b0);
      repeat (int'($urandom_range(0, 3))) begin
        @(negedge clk); #3;
      end
    end
    issue(4, 5, 6, 0, 1, 0, 0, 2, 1'b1);
    issue(3, 7, 2, 2, 0, 0, 3, 0, 1'b1);
    issue(6, 2, 4, 0, 0, 1, 0, 0, 1'b0);

    issue(20, 400, 10, 0, 0, 0, 0, 0, 1'b0);
    while (cyc < last_run.e1 + 100) begin
      @(negedge clk); #3;
    end
    rst = 1'b1;
    #1;
    chk(bus.rdy === 1'b1 && bus.stage === 2'd0 && bus.s_wren === 1'b0 && bus.ksa_en === 1'b0 &&
        bus.prga_en === 1'b0 && bus.done === 1'b0, "reset_midop",
        $sformatf("rdy/stage/wren/done got %b/%0d/%b/%b expected 1/0/0/0",
                  bus.rdy, bus.stage, bus.s_wren, bus.done));
    runs.delete();
    evq.delete();
    eng_rst_req = 1'b1;
    repeat (3) begin
      @(negedge clk); #2;
    end
    rst = 1'b0;
    next_free = cyc;
    issue(5, 6, 7, 0, 0, 0, 0, 0, 1'b0);

    budget = 0;
    while (evq.size() > 0 && budget < 3000) begin
      @(negedge clk); #3;
      budget++;
    end
    repeat (3) @(negedge clk);
    #3;
    chk(evq.size() == 0, "drain",
        $sformatf("pending events got %0d expected 0", evq.size()));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: still running at cyc %0d, required to finish earlier", cyc);
    $fatal(1);
  end
endmodule
